// File: rtl/draw_source_sequencer.sv
// -----------------------------------------------------------------------------
// draw_source_sequencer
//
// Purpose:
//   Shares the frame-buffer write port among several draw sources. The sources
//   sit on a common tri-stated write bus. Each one answers only while
//   write_source_sel carries its own ID.
//
//   On every accepted frame_start the sequencer visits the enabled sources in
//   ascending ID order. ID 0 is the background. The highest ID is drawn last,
//   so it ends up on top.
//
//   For each source the sequencer:
//     1. pulses write_awaited;
//     2. waits for write_active to rise, then to fall;
//     3. holds the select for one GAP cycle so the source can close its write.
//
//   A source that never starts is skipped after START_TIMEOUT cycles. A source
//   that never finishes is aborted after WRITE_TIMEOUT cycles. Either case sets
//   that source's sticky error flag.
//
// Ports:
//   clk              in   system clock
//   reset            in   synchronous, active-high reset
//   frame_start      in   single-cycle request to compose one frame
//   source_enable    in   per-source enable, sampled on an accepted frame_start
//   write_active     in   shared bus write-active line from the granted source
//   write_source_sel out  granted source ID, or IDLE_SEL when nobody is granted
//   write_awaited    out  one-cycle start strobe to the granted source
//   busy             out  high whenever the sequencer is not idle
//   frame_done       out  one-cycle pulse when a composition pass completes
//   frame_overrun    out  one-cycle pulse after a frame_start seen while busy
//   source_error     out  sticky per-source timeout flags, cleared by reset
// -----------------------------------------------------------------------------
module draw_source_sequencer #(
    parameter int NUM_SOURCES      = 4,
    parameter int SOURCE_SEL_ADDRW = 3,
    parameter int IDLE_SEL         = 7,
    parameter int START_TIMEOUT    = 8,
    parameter int WRITE_TIMEOUT    = 80000,
    parameter int TMO_W            = 17
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_start,
    input  logic [NUM_SOURCES-1:0]      source_enable,
    input  logic                        write_active,
    output logic [SOURCE_SEL_ADDRW-1:0] write_source_sel,
    output logic                        write_awaited,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        frame_overrun,
    output logic [NUM_SOURCES-1:0]      source_error
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_SCAN        = 3'd1;
    localparam logic [2:0] S_ISSUE       = 3'd2;
    localparam logic [2:0] S_AWAIT_START = 3'd3;
    localparam logic [2:0] S_AWAIT_END   = 3'd4;
    localparam logic [2:0] S_GAP         = 3'd5;
    localparam logic [2:0] S_DONE        = 3'd6;

    // -------------------------------------------------------------------------
    // Derived constants
    // -------------------------------------------------------------------------
    localparam logic [SOURCE_SEL_ADDRW-1:0] L_IDLE_SEL  = SOURCE_SEL_ADDRW'(IDLE_SEL);
    localparam logic [SOURCE_SEL_ADDRW-1:0] L_LAST_ID   = SOURCE_SEL_ADDRW'(NUM_SOURCES - 1);
    localparam logic [TMO_W-1:0]            L_START_LIM = TMO_W'(START_TIMEOUT - 1);
    localparam logic [TMO_W-1:0]            L_WRITE_LIM = TMO_W'(WRITE_TIMEOUT - 1);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [2:0]                  r_state;
    logic [SOURCE_SEL_ADDRW-1:0] r_sel;
    logic [SOURCE_SEL_ADDRW-1:0] r_index;
    logic [NUM_SOURCES-1:0]      r_snap;
    logic [TMO_W-1:0]            r_cnt;
    logic [NUM_SOURCES-1:0]      r_source_error;
    logic                        r_overrun;

    // -------------------------------------------------------------------------
    // Combinational signals
    // -------------------------------------------------------------------------
    logic [2:0]                  w_state_next;
    logic [NUM_SOURCES-1:0]      w_cand;
    logic                        w_found;
    logic [SOURCE_SEL_ADDRW-1:0] w_found_id;
    logic                        w_start_tmo;
    logic                        w_write_tmo;
    logic [NUM_SOURCES-1:0]      w_err_set;
    logic                        w_cnt_sat;

    // Candidate sources for this SCAN: enabled in the snapshot and not yet
    // visited in this pass. The error flags are set per bit, so an out-of-range
    // select value can never index past the flag vector.
    generate
        for (genvar gi = 0; gi < NUM_SOURCES; gi++) begin : g_src
            localparam logic [SOURCE_SEL_ADDRW-1:0] L_ID = SOURCE_SEL_ADDRW'(gi);
            assign w_cand[gi]    = r_snap[gi] && (L_ID >= r_index);
            assign w_err_set[gi] = (w_start_tmo || w_write_tmo) && (r_sel == L_ID);
        end
    endgenerate

    // Lowest-numbered candidate wins. The loop descends, so the last hit
    // assigned is the lowest ID.
    always_comb begin
        w_found    = 1'b0;
        w_found_id = '0;
        for (int i = NUM_SOURCES - 1; i >= 0; i--) begin
            if (w_cand[i]) begin
                w_found    = 1'b1;
                w_found_id = i[SOURCE_SEL_ADDRW-1:0];
            end
        end
    end

    assign w_cnt_sat   = (r_cnt == {TMO_W{1'b1}});

    // A rising write_active in the last allowed cycle still counts as a start.
    assign w_start_tmo = (r_state == S_AWAIT_START) && !write_active && (r_cnt == L_START_LIM);

    // Symmetrically, a falling write_active in the last cycle counts as a
    // normal finish.
    assign w_write_tmo = (r_state == S_AWAIT_END) && write_active && (r_cnt == L_WRITE_LIM);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                w_state_next = w_found ? S_ISSUE : S_DONE;
            end
            S_ISSUE: begin
                w_state_next = S_AWAIT_START;
            end
            S_AWAIT_START: begin
                if (write_active) begin
                    w_state_next = S_AWAIT_END;
                end else if (w_start_tmo) begin
                    w_state_next = S_GAP;
                end
            end
            S_AWAIT_END: begin
                if (!write_active || w_write_tmo) begin
                    w_state_next = S_GAP;
                end
            end
            S_GAP: begin
                // After the top-most source there is nothing left to scan.
                w_state_next = (r_sel == L_LAST_ID) ? S_DONE : S_SCAN;
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Sequential logic
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_sel          <= L_IDLE_SEL;
            r_index        <= '0;
            r_snap         <= '0;
            r_cnt          <= '0;
            r_source_error <= '0;
            r_overrun      <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_source_error <= r_source_error | w_err_set;

            // Any frame_start outside IDLE is dropped. It is only reported,
            // one cycle later.
            r_overrun      <= frame_start && (r_state != S_IDLE);

            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_snap  <= source_enable;
                        r_index <= '0;
                    end
                end
                S_SCAN: begin
                    // The select is left alone when nothing is found. DONE
                    // returns it to IDLE_SEL.
                    if (w_found) begin
                        r_sel <= w_found_id;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                end
                S_AWAIT_START: begin
                    if (write_active) begin
                        r_cnt <= '0;
                    end else if (!w_cnt_sat) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_AWAIT_END: begin
                    if (!w_cnt_sat) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_GAP: begin
                    // The select is still held on the current ID here.
                    r_index <= r_sel + 1'b1;
                end
                S_DONE: begin
                    r_sel <= L_IDLE_SEL;
                end
                default: begin
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: registered, or decoded from the registered state only
    // -------------------------------------------------------------------------
    assign write_source_sel = r_sel;
    assign write_awaited    = (r_state == S_ISSUE);
    assign busy             = (r_state != S_IDLE);
    assign frame_done       = (r_state == S_DONE);
    assign frame_overrun    = r_overrun;
    assign source_error     = r_source_error;

endmodule

// File: tb/tb_draw_source_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for draw_source_sequencer.
//
// Mock draw sources answer on the shared bus while selected:
//   normal : start 2 cycles after write_awaited, then stay active 16 cycles
//   never  : never raise write_active
//   hang   : raise write_active and never drop it
//
// Expected grants, frame_done cycles and overrun cycles are queued when a
// frame is requested. A monitor pops and compares them as the DUT produces
// its outputs.
// -----------------------------------------------------------------------------
module tb_draw_source_sequencer;

    localparam logic [1:0] M_NORMAL = 2'd0;
    localparam logic [1:0] M_NEVER  = 2'd1;
    localparam logic [1:0] M_HANG   = 2'd2;

    logic       clk = 1'b0;
    logic       reset;
    logic       frame_start;
    logic [3:0] source_enable;
    logic       write_active;
    logic [2:0] write_source_sel;
    logic       write_awaited;
    logic       busy;
    logic       frame_done;
    logic       frame_overrun;
    logic [3:0] source_error;

    draw_source_sequencer #(
        .NUM_SOURCES     (4),
        .SOURCE_SEL_ADDRW(3),
        .IDLE_SEL        (7),
        .START_TIMEOUT   (8),
        .WRITE_TIMEOUT   (32),
        .TMO_W           (17)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .frame_start     (frame_start),
        .source_enable   (source_enable),
        .write_active    (write_active),
        .write_source_sel(write_source_sel),
        .write_awaited   (write_awaited),
        .busy            (busy),
        .frame_done      (frame_done),
        .frame_overrun   (frame_overrun),
        .source_error    (source_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    logic [2:0] exp_grant [$];
    int         exp_done  [$];
    int         exp_ovr   [$];

    int awaited_cyc [4];
    int awaited_total = 0;
    int done_total    = 0;
    int ovr_total     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Mock draw sources on the shared bus
    // -------------------------------------------------------------------------
    logic [1:0] mode [4];
    logic       mk_busy = 1'b0;
    logic [2:0] mk_id   = 3'd0;
    int         mk_start = 0;

    always @(negedge clk) begin
        if (reset) begin
            mk_busy      = 1'b0;
            write_active = 1'b0;
        end else begin
            if (write_awaited) begin
                mk_busy  = 1'b1;
                mk_id    = write_source_sel;
                mk_start = cyc;
            end
            write_active = 1'b0;
            if (mk_busy && (write_source_sel == mk_id) && (mk_id < 3'd4)) begin
                case (mode[mk_id[1:0]])
                    M_NORMAL: write_active = (cyc >= mk_start + 2) && (cyc <= mk_start + 17);
                    M_HANG:   write_active = (cyc >= mk_start + 2);
                    default:  write_active = 1'b0;
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output monitor
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        if (!reset) begin
            if (write_awaited) begin
                awaited_total++;
                n_tests++;
                assert (exp_grant.size() != 0) else begin
                    n_fail++;
                    $error("FAIL grant_unexpected: observed sel %0d expected no grant", write_source_sel);
                end
                if (exp_grant.size() != 0) begin
                    logic [2:0] e;
                    e = exp_grant.pop_front();
                    check("grant_order", {29'd0, write_source_sel}, {29'd0, e});
                end
                if (write_source_sel < 3'd4) begin
                    awaited_cyc[write_source_sel[1:0]] = cyc;
                end
                $display("[TB] cycle %0d: write_awaited sel=%0d", cyc, write_source_sel);
            end

            if (frame_done) begin
                done_total++;
                n_tests++;
                assert (exp_done.size() != 0) else begin
                    n_fail++;
                    $error("FAIL done_unexpected: observed frame_done at cycle %0d expected none", cyc);
                end
                if (exp_done.size() != 0) begin
                    int e;
                    e = exp_done.pop_front();
                    check("done_cycle", cyc, e);
                end
                $display("[TB] cycle %0d: frame_done", cyc);
            end

            if (frame_overrun) begin
                ovr_total++;
                n_tests++;
                assert (exp_ovr.size() != 0) else begin
                    n_fail++;
                    $error("FAIL ovr_unexpected: observed frame_overrun at cycle %0d expected none", cyc);
                end
                if (exp_ovr.size() != 0) begin
                    int e;
                    e = exp_ovr.pop_front();
                    check("overrun_cycle", cyc, e);
                end
                $display("[TB] cycle %0d: frame_overrun", cyc);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------

    // Drive frame_start during cycle t. Returns at the negedge of cycle t+1.
    task automatic pulse_start(input logic [3:0] en, output int t);
        frame_start   = 1'b1;
        source_enable = en;
        t             = cyc;
        @(negedge clk);
        frame_start   = 1'b0;
        source_enable = 4'h0;
    endtask

    // Reference grant order: ascending ID among enabled bits.
    task automatic push_grants(input logic [3:0] en);
        for (int i = 0; i < 4; i++) begin
            if (en[i]) exp_grant.push_back(3'(i));
        end
    endtask

    task automatic clear_awaited();
        for (int i = 0; i < 4; i++) awaited_cyc[i] = -1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    // -------------------------------------------------------------------------
    // Directed stimulus
    // -------------------------------------------------------------------------
    initial begin
        int t;
        int t2;
        int base_aw;
        int base_done;
        int base_ovr;

        reset         = 1'b1;
        frame_start   = 1'b0;
        source_enable = 4'h0;
        for (int i = 0; i < 4; i++) mode[i] = M_NORMAL;
        clear_awaited();

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_sel",     {29'd0, write_source_sel}, 32'd7);
        check("rst_busy",    {31'd0, busy},             32'd0);
        check("rst_awaited", {31'd0, write_awaited},    32'd0);
        check("rst_done",    {31'd0, frame_done},       32'd0);
        check("rst_ovr",     {31'd0, frame_overrun},    32'd0);
        check("rst_err",     {28'd0, source_error},     32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Enables 1011: grant order 0, 1, 3.
        // Each source takes 21 cycles; DONE follows source 3's GAP directly.
        clear_awaited();
        base_aw   = awaited_total;
        base_done = done_total;
        pulse_start(4'b1011, t);
        push_grants(4'b1011);
        exp_done.push_back(t + 64);
        wait_idle("t2_idle");
        check("t2_aw0",     awaited_cyc[0],            t + 2);
        check("t2_aw1",     awaited_cyc[1],            t + 23);
        check("t2_aw3",     awaited_cyc[3],            t + 44);
        check("t2_aw2_none", awaited_cyc[2],           -1);
        check("t2_aw_count", awaited_total - base_aw,  3);
        check("t2_done_count", done_total - base_done, 1);

        // Empty snapshot: IDLE -> SCAN -> DONE.
        // A frame_start in the DONE cycle is an overrun.
        @(negedge clk);
        pulse_start(4'b0000, t);
        exp_done.push_back(t + 2);
        check("t3_busy1", {31'd0, busy},             32'd1);
        check("t3_sel1",  {29'd0, write_source_sel}, 32'd7);
        @(negedge clk);
        check("t3_busy2", {31'd0, busy},             32'd1);
        check("t3_done2", {31'd0, frame_done},       32'd1);
        check("t3_sel2",  {29'd0, write_source_sel}, 32'd7);
        frame_start   = 1'b1;
        source_enable = 4'b1111;
        exp_ovr.push_back(t + 3);
        @(negedge clk);
        frame_start   = 1'b0;
        source_enable = 4'h0;
        check("t3_busy3", {31'd0, busy},             32'd0);
        check("t3_ovr3",  {31'd0, frame_overrun},    32'd1);
        check("t3_sel3",  {29'd0, write_source_sel}, 32'd7);
        @(negedge clk);
        check("t3_busy4", {31'd0, busy},             32'd0);
        check("t3_ovr4",  {31'd0, frame_overrun},    32'd0);

        // Source 2 never starts: 8 AWAIT_START cycles, then source 3.
        clear_awaited();
        mode[2] = M_NEVER;
        pulse_start(4'b1100, t);
        push_grants(4'b1100);
        exp_done.push_back(t + 33);
        wait_idle("t4_idle");
        check("t4_aw3", awaited_cyc[3],        t + 13);
        check("t4_err", {28'd0, source_error}, 32'h4);

        // The error flag survives the next frame.
        mode[2] = M_NORMAL;
        pulse_start(4'b0001, t);
        push_grants(4'b0001);
        exp_done.push_back(t + 23);
        wait_idle("t4b_idle");
        check("t4_err_sticky", {28'd0, source_error}, 32'h4);

        // Source 1 hangs: aborted after 32 AWAIT_END cycles, frame completes.
        clear_awaited();
        mode[1] = M_HANG;
        pulse_start(4'b0011, t);
        push_grants(4'b0011);
        exp_done.push_back(t + 60);
        repeat (56) @(negedge clk);
        check("t5_sel_hold", {29'd0, write_source_sel}, 32'd1);
        check("t5_err_pre",  {28'd0, source_error},     32'h4);
        wait_idle("t5_idle");
        check("t5_err", {28'd0, source_error}, 32'h6);
        mode[1] = M_NORMAL;

        // Overrun while source 0 writes, with the enables changed in the same
        // cycle. The original snapshot 0101 must still be honoured.
        clear_awaited();
        base_ovr = ovr_total;
        pulse_start(4'b0101, t);
        push_grants(4'b0101);
        exp_done.push_back(t + 44);
        repeat (9) @(negedge clk);
        frame_start   = 1'b1;
        source_enable = 4'b1010;
        exp_ovr.push_back(t + 11);
        @(negedge clk);
        frame_start   = 1'b0;
        source_enable = 4'h0;
        wait_idle("t6_idle");
        check("t6_aw2",      awaited_cyc[2],         t + 23);
        check("t6_aw1_none", awaited_cyc[1],         -1);
        check("t6_aw3_none", awaited_cyc[3],         -1);
        check("t6_ovr_count", ovr_total - base_ovr, 1);

        // Reset held 3 cycles during source 1's write, then restart from 0.
        clear_awaited();
        pulse_start(4'b0011, t);
        push_grants(4'b0011);
        repeat (29) @(negedge clk);
        check("t1_pre_sel",  {29'd0, write_source_sel}, 32'd1);
        check("t1_pre_busy", {31'd0, busy},             32'd1);
        reset = 1'b1;
        exp_grant.delete();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t1_sel",     {29'd0, write_source_sel}, 32'd7);
        check("t1_busy",    {31'd0, busy},             32'd0);
        check("t1_awaited", {31'd0, write_awaited},    32'd0);
        check("t1_err",     {28'd0, source_error},     32'd0);
        clear_awaited();
        pulse_start(4'b0001, t2);
        push_grants(4'b0001);
        exp_done.push_back(t2 + 23);
        wait_idle("t1_idle");
        check("t1_restart_aw0", awaited_cyc[0], t2 + 2);

        // Every queued expectation must have been consumed.
        repeat (2) @(negedge clk);
        check("sb_grants_left", exp_grant.size(), 0);
        check("sb_done_left",   exp_done.size(),  0);
        check("sb_ovr_left",    exp_ovr.size(),   0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Watchdog: the directed sequence needs well under 1000 cycles.
    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion expected finish before 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
